// File: rtl/chain_mem_unit.sv
// Block-pool manager that builds and frees linked block chains. A next-pointer array
// links the chains. New blocks come from a LIFO free list first, then from a watermark of blocks never used.
module chain_mem_unit #(
    parameter int NUM_BLOCKS = 1024,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS),
    parameter int LEN_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    input  logic [LEN_W-1:0]  alloc_len,
    output logic              alloc_gnt,
    output logic              alloc_fail,
    output logic              blk_valid,
    output logic [ADDR_W-1:0] blk_addr,
    output logic              blk_last,
    output logic              alloc_done,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] free_head,
    output logic              free_ack,
    output logic              free_done,
    output logic [ADDR_W:0]   free_count,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: alloc_req/free_req are levels held by the requester until the
    // matching single-cycle response pulse; they are only examined in IDLE.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_ATERM = 2'd2,
        ST_FREE  = 2'd3
    } state_t;

    localparam int CW = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
    localparam logic [ADDR_W:0] CNT_MAX   = (ADDR_W + 1)'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W:0] FRESH_RST = (ADDR_W + 1)'(1);

    state_t             state, state_d;
    logic [ADDR_W-1:0]  fl_head, fl_head_d;
    logic [ADDR_W:0]    fresh, fresh_d;
    logic [ADDR_W-1:0]  cur, cur_d;
    logic [ADDR_W-1:0]  prev, prev_d;
    logic [LEN_W-1:0]   remaining, remaining_d;
    logic [ADDR_W:0]    cnt_d;

    logic [ADDR_W-1:0]  next_mem [NUM_BLOCKS];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0]  mem_wdata;

    logic               pop_from_fl;
    logic [ADDR_W-1:0]  pop_blk;
    logic [ADDR_W-1:0]  fl_nxt;
    logic [ADDR_W-1:0]  cur_nxt;
    logic [CW-1:0]      len_ext;
    logic [CW-1:0]      cnt_ext;

    assign pop_from_fl = (fl_head != '0);
    assign pop_blk     = pop_from_fl ? fl_head : fresh[ADDR_W-1:0];
    assign fl_nxt      = next_mem[fl_head];
    assign cur_nxt     = next_mem[cur];
    assign len_ext     = CW'(alloc_len);
    assign cnt_ext     = CW'(free_count);
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    // The array carries no reset: fl_head=0 and fresh=1 make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            next_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fl_head    <= '0;
            fresh      <= FRESH_RST;
            cur        <= '0;
            prev       <= '0;
            remaining  <= '0;
            free_count <= CNT_MAX;
        end else begin
            state      <= state_d;
            fl_head    <= fl_head_d;
            fresh      <= fresh_d;
            cur        <= cur_d;
            prev       <= prev_d;
            remaining  <= remaining_d;
            free_count <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        fl_head_d   = fl_head;
        fresh_d     = fresh;
        cur_d       = cur;
        prev_d      = prev;
        remaining_d = remaining;
        cnt_d       = free_count;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        alloc_gnt   = 1'b0;
        alloc_fail  = 1'b0;
        blk_valid   = 1'b0;
        blk_addr    = '0;
        blk_last    = 1'b0;
        alloc_done  = 1'b0;
        free_ack    = 1'b0;
        free_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (free_req) begin
                    free_ack = 1'b1;
                    if (free_head == '0) begin
                        free_done = 1'b1;
                    end else begin
                        cur_d   = free_head;
                        state_d = ST_FREE;
                    end
                end else if (alloc_req) begin
                    if ((alloc_len == '0) || (len_ext > cnt_ext)) begin
                        alloc_fail = 1'b1;
                    end else begin
                        alloc_gnt   = 1'b1;
                        remaining_d = alloc_len;
                        prev_d      = '0;
                        state_d     = ST_ALLOC;
                    end
                end
            end

            ST_ALLOC: begin
                blk_valid = 1'b1;
                blk_addr  = pop_blk;
                blk_last  = (remaining == LEN_W'(1));
                if (pop_from_fl) begin
                    fl_head_d = fl_nxt;
                end else begin
                    fresh_d = fresh + (ADDR_W + 1)'(1);
                end
                // Link the previous block to this one; the head has no predecessor.
                if (prev != '0) begin
                    mem_we    = 1'b1;
                    mem_waddr = prev;
                    mem_wdata = pop_blk;
                end
                prev_d      = pop_blk;
                remaining_d = remaining - LEN_W'(1);
                if (free_count != '0) begin
                    cnt_d = free_count - (ADDR_W + 1)'(1);
                end
                if (remaining == LEN_W'(1)) begin
                    state_d = ST_ATERM;
                end
            end

            ST_ATERM: begin
                mem_we     = 1'b1;
                mem_waddr  = prev;
                mem_wdata  = '0;
                alloc_done = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_FREE: begin
                // Read of next[cur] happens before the push overwrites it.
                mem_we    = 1'b1;
                mem_waddr = cur;
                mem_wdata = fl_head;
                fl_head_d = cur;
                if (free_count != CNT_MAX) begin
                    cnt_d = free_count + (ADDR_W + 1)'(1);
                end
                if (cur_nxt == '0) begin
                    free_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cur_d = cur_nxt;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/chain_mem_unit.md
# chain_mem_unit

Parametrised successor to the control-memory unit. It manages the packet buffer's block pool as linked chains held in an internal next-pointer array. On an allocate request it builds a chain of N blocks, streaming one block address per cycle. On a free request it walks a chain from its head and returns every block to the pool. It sits between the ingress writer, which allocates, and the egress reader, which frees, and it owns the authoritative free-block count.

## Interface
- NUM_BLOCKS, 1024, total block slots; slot 0 is the reserved null/end-of-chain marker, so usable capacity is NUM_BLOCKS-1.
- ADDR_W, $clog2(NUM_BLOCKS), block address width.
- LEN_W, 6, width of the requested length in blocks.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- alloc_req  in  1  level; held until alloc_gnt or alloc_fail.
- alloc_len  in  LEN_W  blocks requested; stable while alloc_req is high.
- alloc_gnt  out  1  one-cycle pulse: request accepted.
- alloc_fail  out  1  one-cycle pulse: request rejected; nothing changes.
- blk_valid  out  1  an allocated block address is on blk_addr.
- blk_addr  out  ADDR_W  allocated block address; the first one is the chain head.
- blk_last  out  1  qualifies the final blk_valid of a chain.
- alloc_done  out  1  pulse: chain terminated in the array.
- free_req  in  1  level; held until free_ack.
- free_head  in  ADDR_W  head of the chain to release.
- free_ack  out  1  pulse: free request accepted.
- free_done  out  1  pulse: whole chain returned to the pool.
- free_count  out  ADDR_W+1  number of free blocks.
- busy  out  1  high in every state except IDLE.

## Operation
- Storage: next[0..NUM_BLOCKS-1], ADDR_W bits each, with combinational read and one write port (a second port is used only where stated). The array is not reset; state below makes that safe.
- Pool sources:
  - Free-list stack: register fl_head, 0 = empty, linked through next[].
  - Fresh watermark: register fresh, running 1..NUM_BLOCKS-1, marking never-used blocks; fresh == NUM_BLOCKS means the watermark is exhausted.
- Pop rule: if fl_head != 0, take fl_head and set fl_head <= next[fl_head]. Otherwise take fresh and set fresh <= fresh+1.
- Push rule for block b: next[b] <= fl_head; fl_head <= b.
- States:
  - IDLE: free_req takes priority over alloc_req when both are high.
  - Free accept: assert free_ack. If free_head == 0, pulse free_done in the same cycle and stay in IDLE. Otherwise latch cur <= free_head and go to FREE.
  - Alloc reject: if alloc_len == 0 or alloc_len > free_count, pulse alloc_fail and stay in IDLE.
  - Alloc accept: otherwise pulse alloc_gnt, latch remaining <= alloc_len, set prev <= 0, and go to ALLOC.
  - ALLOC: each cycle pop block b and drive blk_valid=1, blk_addr=b, blk_last=(remaining==1). If prev != 0, write next[prev] <= b. Then prev <= b, remaining--, free_count--. When remaining reaches 1, go to ATERM on the next edge.
  - ATERM: write next[prev] <= 0, pulse alloc_done, go to IDLE.
  - FREE: each cycle read nxt = next[cur], push cur, free_count++. If nxt == 0, pulse free_done and go to IDLE; otherwise cur <= nxt.
- Width rules:
  - free_count resets to NUM_BLOCKS-1 and never exceeds it or goes below 0.
  - alloc_len is zero-extended for the compare.
- Freeing an unallocated block, or a chain that is still being allocated, is a caller error. Behaviour in that case is undefined.

## Timing
- Reset state:
  - All output pulses and blk_valid are 0; busy=0.
  - blk_addr=0, free_count=NUM_BLOCKS-1.
  - fl_head=0, fresh=1, state IDLE.
- Reset asserted mid-operation aborts the operation immediately. Partial chains are discarded because the pool restarts from the watermark.
- Alloc of N blocks:
  - Accept cycle T: alloc_gnt.
  - blk_valid during T+1..T+N.
  - alloc_done at T+N+1.
  - IDLE at T+N+2.
- Free of an N-block chain:
  - free_ack at T.
  - Walk cycles T+1..T+N; free_done coincides with cycle T+N.
  - IDLE at T+N+1.
- Requests arriving while busy stay pending. They are evaluated only in IDLE.
- free_count updates on the edge that ends each ALLOC or FREE cycle. An alloc decided in IDLE sees the value that includes every completed free.
- Exhaustion: an allocation of exactly free_count blocks succeeds and leaves free_count=0. Every further request then fails.

## Test plan
- Allocate after reset:
  - Stimulus: reset, then alloc_len=3.
  - Response: alloc_gnt; blk_addr 1,2,3 with blk_last on 3; alloc_done; free_count=NUM_BLOCKS-4.
  - Array check by a second test: freeing head 1 takes exactly 3 walk cycles.
- Free then reuse:
  - Stimulus: allocate 1,2,3; free head 1; then alloc_len=2.
  - Response: blocks 3,2 (LIFO reuse from the free list); free_count=NUM_BLOCKS-3.
- Mixed sources:
  - Stimulus: allocate 2 (blocks 1,2), free head 1, then alloc_len=4.
  - Response: blocks 2,1,3,4, taking the free list first and then the watermark.
- Exhaustion with NUM_BLOCKS=16:
  - Stimulus: alloc_len=15, then alloc_len=1.
  - Response: the first succeeds with free_count=0; the second gives alloc_fail and no state change.
  - Also: alloc_len=0 gives alloc_fail.
- Simultaneous requests:
  - Stimulus: alloc_req and free_req raised in the same IDLE cycle.
  - Response: free_ack first; alloc_gnt only after free_done plus one cycle.
  - Also: free_head=0 gives free_ack and free_done together.
- Reset mid-walk:
  - Stimulus: assert reset asynchronously during FREE of a 5-block chain.
  - Response: outputs go immediately to their reset values; free_count=NUM_BLOCKS-1; the next alloc returns block 1.
